// File: rtl/clkgen_preset_sequencer.sv
// Preset sequencer feeding the clock_generator reconfiguration port.
// Steps through four fixed M/D/O presets, retries failed attempts, flags errors.
module clkgen_preset_sequencer #(
    parameter int unsigned START_WIDTH  = 7,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRIES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       sel_valid,
    input  logic [1:0] sel_idx,
    input  logic       program_done,
    input  logic       locked,
    output logic [7:0] O,
    output logic [3:0] D,
    output logic [6:0] M,
    output logic       start,
    output logic       busy,
    output logic [1:0] cur_idx,
    output logic       error,
    output logic [2:0] retry_cnt,
    output logic       req_dropped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_WAIT_LOCK,
        S_SUCCESS,
        S_FAIL,
        S_ERROR
    } state_e;

    localparam logic [15:0] START_LAST = 16'(START_WIDTH - 1);
    localparam logic [15:0] BUSY_LAST  = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0] LOCK_LAST  = 16'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]  RETRY_MAX  = 3'(MAX_RETRIES);

    // Packed as {O, D, M}
    function automatic logic [18:0] preset(input logic [1:0] idx);
        logic [18:0] p;
        unique case (idx)
            2'd0: p = {8'd100, 4'd4, 7'd7};
            2'd1: p = {8'd125, 4'd8, 7'd35};
            2'd2: p = {8'd25, 4'd4, 7'd7};
            2'd3: p = {8'd25, 4'd4, 7'd42};
        endcase
        return p;
    endfunction

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [1:0]  cur_q, cur_d;
    logic [2:0]  retry_q, retry_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        start_q, start_d;
    logic        drop_q, drop_d;
    logic [7:0]  odiv_q, odiv_d;
    logic [3:0]  idiv_q, idiv_d;
    logic [6:0]  mult_q, mult_d;

    logic rq;
    logic accept;

    assign rq     = req | sel_valid;
    assign accept = rq && program_done
                 && (state_q == S_IDLE || state_q == S_ERROR);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        retry_d = retry_q;
        err_d   = err_q;
        odiv_d  = odiv_q;
        idiv_d  = idiv_q;
        mult_d  = mult_q;
        drop_d  = rq && !accept;

        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (accept) begin
                    // sel_valid has priority; a coincident req is absorbed
                    tgt_d   = sel_valid ? sel_idx : cur_q + 2'd1;
                    {odiv_d, idiv_d, mult_d} = preset(tgt_d);
                    err_d   = 1'b0;
                    retry_d = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == START_LAST) state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!program_done)          state_d = S_WAIT_DONE;
                else if (cnt_q == BUSY_LAST) state_d = S_FAIL;
            end
            S_WAIT_DONE: begin
                if (program_done) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked)                  state_d = S_SUCCESS;
                else if (cnt_q == LOCK_LAST) state_d = S_FAIL;
            end
            S_SUCCESS: begin
                cur_d   = tgt_q;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 3'd1;
                    state_d = S_START;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = 16'd0;

        busy_d  = !(state_d == S_IDLE || state_d == S_ERROR);
        start_d = (state_d == S_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            tgt_q   <= 2'd0;
            cur_q   <= 2'd0;
            retry_q <= 3'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
            odiv_q  <= 8'd100;
            idiv_q  <= 4'd4;
            mult_q  <= 7'd7;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            drop_q  <= drop_d;
            odiv_q  <= odiv_d;
            idiv_q  <= idiv_d;
            mult_q  <= mult_d;
        end
    end

    assign O           = odiv_q;
    assign D           = idiv_q;
    assign M           = mult_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign cur_idx     = cur_q;
    assign error       = err_q;
    assign retry_cnt   = retry_q;
    assign req_dropped = drop_q;

endmodule

// File: tb/tb_clkgen_preset_sequencer.sv
// Bench for clkgen_preset_sequencer: procedural reference model, per-cycle
// compare, a generator responder and directed scenarios with literal checks.
module tb_clkgen_preset_sequencer;

    localparam int SW = 7;
    localparam int BT = 16;
    localparam int LT = 32;
    localparam int MR = 2;

    localparam int NORM   = 0;
    localparam int NOLOCK = 1;
    localparam int NODROP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_idx = 2'd0;
    logic       program_done;
    logic       locked;
    logic [7:0] O;
    logic [3:0] D;
    logic [6:0] M;
    logic       start;
    logic       busy;
    logic [1:0] cur_idx;
    logic       error;
    logic [2:0] retry_cnt;
    logic       req_dropped;

    clkgen_preset_sequencer #(
        .START_WIDTH (SW),
        .BUSY_TIMEOUT(BT),
        .LOCK_TIMEOUT(LT),
        .MAX_RETRIES (MR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .program_done(program_done),
        .locked      (locked),
        .O           (O),
        .D           (D),
        .M           (M),
        .start       (start),
        .busy        (busy),
        .cur_idx     (cur_idx),
        .error       (error),
        .retry_cnt   (retry_cnt),
        .req_dropped (req_dropped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = NORM;
    int bursts = 0;
    int hi_cyc = 0;
    int drops  = 0;

    // Preset table (M, D, O)
    int tM [4] = '{7, 35, 7, 42};
    int tD [4] = '{4, 8, 4, 4};
    int tO [4] = '{100, 125, 25, 25};

    // Expected outputs
    logic [7:0] e_O;
    logic [3:0] e_D;
    logic [6:0] e_M;
    logic       e_start, e_busy, e_err, e_drop;
    logic [1:0] e_cur;
    logic [2:0] e_retry;
    bit         ab;

    function automatic void reset_exp();
        e_O = 8'd100; e_D = 4'd4; e_M = 7'd7;
        e_start = 0; e_busy = 0; e_err = 0; e_drop = 0;
        e_cur = 0; e_retry = 0;
    endfunction

    // One clock of an in-progress sequence: any request is dropped
    task automatic btick();
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ab = 1;
            reset_exp();
        end else begin
            e_drop = req | sel_valid;
        end
    endtask

    task automatic run_seq(input int t);
        bit ok;
        forever begin
            for (int i = 1; i < SW; i++) begin
                btick(); if (ab) return;
            end
            btick(); if (ab) return;
            e_start = 0;
            ok = 0;
            for (int k = 1; k <= BT; k++) begin
                btick(); if (ab) return;
                if (!program_done) begin ok = 1; break; end
            end
            if (ok) begin
                do begin
                    btick(); if (ab) return;
                end while (!program_done);
                ok = 0;
                for (int k = 1; k <= LT; k++) begin
                    btick(); if (ab) return;
                    if (locked) begin ok = 1; break; end
                end
            end
            btick(); if (ab) return;
            if (ok) begin
                e_cur = 2'(t); e_busy = 0;
                return;
            end
            if (int'(e_retry) < MR) begin
                e_retry = e_retry + 3'd1;
                e_start = 1;
            end else begin
                e_err = 1; e_busy = 0;
                return;
            end
        end
    endtask

    initial begin : model
        int t;
        reset_exp();
        forever begin
            ab = 0;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                reset_exp();
            end else begin
                e_drop = 0;
                if (req || sel_valid) begin
                    if (!program_done) begin
                        e_drop = 1;
                    end else begin
                        t = sel_valid ? int'(sel_idx) : (int'(e_cur) + 1) % 4;
                        e_O = 8'(tO[t]); e_D = 4'(tD[t]); e_M = 7'(tM[t]);
                        e_err = 0; e_retry = 0; e_busy = 1; e_start = 1;
                        run_seq(t);
                    end
                end
            end
        end
    end

    // Per-cycle compare plus activity counters
    initial begin : cmp
        logic [31:0] act, exp;
        logic prev_start = 0;
        forever begin
            @(negedge clk);
            act = {2'b0, start, busy, error, cur_idx, retry_cnt,
                   req_dropped, O, D, M};
            exp = {2'b0, e_start, e_busy, e_err, e_cur, e_retry,
                   e_drop, e_O, e_D, e_M};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL cycle t=%0t outputs got=%h want=%h", $time, act, exp);
            end
            if (start && !prev_start) bursts++;
            if (start) hi_cyc++;
            if (req_dropped) drops++;
            prev_start = start;
        end
    end

    // Generator responder
    initial begin : gen
        int t = 0;
        bit ph = 0;
        program_done = 1;
        locked = 1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = 0; program_done = 1; locked = 1;
            end else if (start) begin
                ph = 1; t = 0;
                if (mode != NODROP) locked = 0;
            end else if (ph) begin
                t++;
                if (mode == NODROP) begin
                    ph = 0;
                end else begin
                    if (t == 3) program_done = 0;
                    if (t == 23) program_done = 1;
                    if (t == 33) begin
                        if (mode == NORM) locked = 1;
                        ph = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic pulse(input bit r, input bit s, input logic [1:0] idx);
        @(negedge clk);
        req = r; sel_valid = s; sel_idx = idx;
        @(negedge clk);
        req = 0; sel_valid = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        if (busy) begin
            n_cmp++; n_bad++;
            $display("FAIL %s busy still 1 after %0d cycles", nm, n);
        end
    endtask

    task automatic wait_pd(input logic v, input string nm);
        int n = 0;
        while (program_done !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (program_done !== v) begin
            n_cmp++; n_bad++;
            $display("FAIL %s program_done never reached %0b", nm, v);
        end
    endtask

    initial begin : stim
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_O", int'(O), 100);
        chk("rst_D", int'(D), 4);
        chk("rst_M", int'(M), 7);
        chk("rst_cur", int'(cur_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(error), 0);
        chk("rst_start", int'(start), 0);

        hi_cyc = 0;
        pulse(1, 0, 0);
        chk("req_O", int'(O), 125);
        chk("req_D", int'(D), 8);
        chk("req_M", int'(M), 35);
        wait_idle("seq1");
        chk("start_width", hi_cyc, 7);
        chk("seq1_cur", int'(cur_idx), 1);

        drops = 0;
        pulse(1, 1, 2'd3);
        chk("sel_M", int'(M), 42);
        wait_idle("sel3");
        chk("sel_cur", int'(cur_idx), 3);
        chk("sel_nodrop", drops, 0);

        drops = 0;
        pulse(1, 0, 0);
        repeat (5) @(negedge clk);
        pulse(1, 0, 0);
        chk("drop_O", int'(O), 100);
        wait_idle("drop");
        chk("drop_cnt", drops, 1);
        chk("drop_cur", int'(cur_idx), 0);

        mode = NOLOCK;
        bursts = 0;
        pulse(1, 0, 0);
        wait_idle("nolock");
        chk("nolock_bursts", bursts, 3);
        chk("nolock_retry", int'(retry_cnt), 2);
        chk("nolock_err", int'(error), 1);
        chk("nolock_cur", int'(cur_idx), 0);
        chk("nolock_O", int'(O), 125);

        mode = NORM;
        pulse(1, 0, 0);
        chk("recover_errclr", int'(error), 0);
        wait_idle("recover");
        chk("recover_cur", int'(cur_idx), 1);

        mode = NODROP;
        bursts = 0;
        pulse(1, 0, 0);
        wait_idle("nodrop");
        chk("nodrop_bursts", bursts, 3);
        chk("nodrop_err", int'(error), 1);
        chk("nodrop_cur", int'(cur_idx), 1);

        mode = NORM;
        pulse(1, 0, 0);
        chk("rst2_O", int'(O), 25);
        wait_pd(0, "rst2_fall");
        wait_pd(1, "rst2_rise");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_start", int'(start), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_O", int'(O), 100);
        chk("arst_M", int'(M), 7);
        chk("arst_cur", int'(cur_idx), 0);
        chk("arst_err", int'(error), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        pulse(1, 0, 0);
        wait_idle("post_rst");
        chk("post_rst_cur", int'(cur_idx), 1);
        chk("post_rst_O", int'(O), 125);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
